// File: rtl/hb_decim2_pkg.sv
// Shared widths and tap constants for the half-band decimate-by-2 stage.
// Latency: n/a (package only).
// Backpressure: n/a.
package hb_decim2_pkg;
  localparam int BW    = 6;
  localparam int W     = BW + 5;
  localparam int ACC_W = W + 6;
  localparam int OUT_W = W + 1;

  localparam int C_CENTER = 16;
  localparam int C_NEAR   = 9;
  localparam int C_FAR    = -1;

  localparam int RND = 16;
  localparam int SH  = 5;
  localparam int CENTER_SH = $clog2(C_CENTER);
endpackage

// File: rtl/hb_symmetric_tap.sv
// Registered pre-add of a symmetric sample pair, then shift-add scaling by COEF.
// Latency: 1 cycle for the pre-add; scaling is combinational after the register.
// Backpressure: none; loads on ld, clears synchronously on clr.
module hb_symmetric_tap
  import hb_decim2_pkg::*;
#(
  parameter int COEF = C_NEAR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld,
  input  logic                    clr,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  output logic signed [ACC_W-1:0] term
);
  logic signed [W:0]       sum_q;
  logic signed [ACC_W-1:0] sum_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (ld) begin
      sum_q <= (W+1)'(a) + (W+1)'(b);
    end
  end

  assign sum_x = ACC_W'(sum_q);

  // Only the coefficients this filter uses are built; anything else passes through.
  generate
    if (COEF == C_NEAR) begin : g_near
      assign term = (sum_x <<< 3) + sum_x;
    end else if (COEF == C_FAR) begin : g_far
      assign term = -sum_x;
    end else begin : g_unity
      assign term = sum_x;
    end
  endgenerate
endmodule

// File: rtl/hb_decim2_filter.sv
// 7-tap half-band decimate-by-2 filter on paired CIC phases, multiplier-free.
// Latency: 2 cycles from accepted pair to OUT/OUT_VALID; one pair per cycle.
// Backpressure: none; ENABLE low flushes state and drops in-flight valids.
module hb_decim2_filter
  import hb_decim2_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RES,
  input  logic                    ENABLE,
  input  logic                    IN_VALID,
  input  logic signed [W-1:0]     IN1,
  input  logic signed [W-1:0]     IN2,
  output logic                    OUT_VALID,
  output logic signed [OUT_W-1:0] OUT
);
  logic                    accept;
  logic signed [W-1:0]     o1_q, o2_q, o3_q, e1_q;
  logic [1:0]              prime_cnt;
  logic                    s1_vld;
  logic signed [ACC_W-1:0] center_q;
  logic signed [ACC_W-1:0] near_term, far_term;
  logic signed [ACC_W-1:0] acc, acc_rnd;

  assign accept = ENABLE & IN_VALID;

  // o0 is IN2 itself; the registers hold the three previous odd samples and last even one.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      o1_q      <= '0;
      o2_q      <= '0;
      o3_q      <= '0;
      e1_q      <= '0;
      prime_cnt <= '0;
      s1_vld    <= 1'b0;
      center_q  <= '0;
    end else if (!ENABLE) begin
      o1_q      <= '0;
      o2_q      <= '0;
      o3_q      <= '0;
      e1_q      <= '0;
      prime_cnt <= '0;
      s1_vld    <= 1'b0;
      center_q  <= '0;
    end else begin
      s1_vld <= IN_VALID && (prime_cnt == 2'd3);
      if (IN_VALID) begin
        o1_q     <= IN2;
        o2_q     <= o1_q;
        o3_q     <= o2_q;
        e1_q     <= IN1;
        center_q <= ACC_W'(e1_q) <<< CENTER_SH;
        if (prime_cnt != 2'd3) begin
          prime_cnt <= prime_cnt + 2'd1;
        end
      end
    end
  end

  hb_symmetric_tap #(.COEF(C_NEAR)) u_tap_near (
    .clk   (CLK),
    .rst_n (RES),
    .ld    (accept),
    .clr   (~ENABLE),
    .a     (o1_q),
    .b     (o2_q),
    .term  (near_term)
  );

  hb_symmetric_tap #(.COEF(C_FAR)) u_tap_far (
    .clk   (CLK),
    .rst_n (RES),
    .ld    (accept),
    .clr   (~ENABLE),
    .a     (IN2),
    .b     (o3_q),
    .term  (far_term)
  );

  assign acc     = center_q + near_term + far_term;
  assign acc_rnd = acc + ACC_W'(RND);

  // Output magnitude is bounded by the tap sum, so the narrowing below never wraps.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      OUT_VALID <= 1'b0;
      OUT       <= '0;
    end else if (!ENABLE) begin
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= s1_vld;
      if (s1_vld) begin
        OUT <= OUT_W'(acc_rnd >>> SH);
      end
    end
  end
endmodule

// File: tb/tb_hb_decim2_filter.sv
// Scoreboarded bench for hb_decim2_filter: reference model pushes expected outputs
// with their due cycle; a monitor pops and compares on each OUT_VALID strobe.
module tb_hb_decim2_filter;
  import hb_decim2_pkg::*;

  localparam int NO_LIT = 2147483647;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic                    CLK;
  logic                    RES;
  logic                    ENABLE;
  logic                    IN_VALID;
  logic signed [W-1:0]     IN1;
  logic signed [W-1:0]     IN2;
  logic                    OUT_VALID;
  logic signed [OUT_W-1:0] OUT;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  int   last_exp_out = 0;
  int   m_o1, m_o2, m_o3, m_e1, m_prime;

  hb_decim2_filter dut (
    .CLK       (CLK),
    .RES       (RES),
    .ENABLE    (ENABLE),
    .IN_VALID  (IN_VALID),
    .IN1       (IN1),
    .IN2       (IN2),
    .OUT_VALID (OUT_VALID),
    .OUT       (OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int rnd_sample();
    return int'($urandom_range(2047, 0)) - 1024;
  endfunction

  task automatic model_clear();
    m_o1 = 0; m_o2 = 0; m_o3 = 0; m_e1 = 0; m_prime = 0;
  endtask

  // Presents one pair for one cycle; lit overrides the model with a hand-derived value.
  task automatic send(input int i1, input int i2, input int lit = NO_LIT);
    int   acc;
    exp_t e;
    ENABLE   = 1'b1;
    IN_VALID = 1'b1;
    IN1      = W'(i1);
    IN2      = W'(i2);
    acc = 16 * m_e1 + 9 * (m_o1 + m_o2) - (i2 + m_o3);
    if (m_prime == 3) begin
      e.val = (lit == NO_LIT) ? ((acc + 16) >>> 5) : lit;
      e.due = cyc + 2;
      sb.push_back(e);
    end else begin
      m_prime++;
    end
    m_o3 = m_o2; m_o2 = m_o1; m_o1 = i2; m_e1 = i1;
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      ENABLE   = 1'b1;
      IN_VALID = 1'b0;
      IN1      = W'(rnd_sample());
      IN2      = W'(rnd_sample());
      @(posedge CLK); #1;
    end
  endtask

  task automatic scoreboard_monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RES) begin
        if (OUT_VALID) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe cyc=%0d OUT=%0d, required no strobe", cyc, OUT);
          end else begin
            e = sb.pop_front();
            last_exp_out = e.val;
            if (OUT !== OUT_W'(e.val) || cyc != e.due) begin
              n_fail++;
              $display("FAIL sb_output cyc=%0d OUT=%0d, required %0d at cyc %0d", cyc, OUT, e.val, e.due);
            end
          end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
          n_checks++;
          n_fail++;
          e = sb.pop_front();
          last_exp_out = e.val;
          $display("FAIL missing_strobe cyc=%0d OUT_VALID=0, required %0d at cyc %0d", cyc, e.val, e.due);
        end
      end
    end
  endtask

  task automatic test_reset();
    RES = 1'b0; ENABLE = 1'b1; IN_VALID = 1'b1;
    model_clear();
    repeat (3) begin
      IN1 = W'(rnd_sample());
      IN2 = W'(rnd_sample());
      @(posedge CLK); #1;
      n_checks++;
      if (OUT !== '0 || OUT_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold OUT=%0d OUT_VALID=%b, required 0/0", OUT, OUT_VALID);
      end
    end
    RES = 1'b1; IN_VALID = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      n_checks++;
      if (OUT !== '0 || OUT_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release_idle OUT=%0d OUT_VALID=%b, required 0/0", OUT, OUT_VALID);
      end
    end
  endtask

  task automatic test_dc();
    repeat (10) send(100, 100, 100);
    idle(4);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL dc_drain pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_impulse_odd(input int gap);
    int lit_v[5];
    int in2_v[5];
    lit_v = '{-1, 9, 9, -1, 0};
    in2_v = '{32, 0, 0, 0, 0};
    repeat (3) begin
      send(0, 0);
      idle(gap);
    end
    for (int i = 0; i < 5; i++) begin
      send(0, in2_v[i], lit_v[i]);
      idle(gap);
    end
    idle(4);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL impulse_odd_drain gap=%0d pending=%0d, required 0", gap, sb.size());
    end
  endtask

  task automatic test_impulse_even();
    repeat (3) send(0, 0);
    send(32, 0, 0);
    send(0, 0, 16);
    send(0, 0, 0);
    send(0, 0, 0);
    idle(4);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL impulse_even_drain pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_extremes();
    repeat (3) send(-1024, -1024);
    send(-1024, -1024, -1024);
    send(0, 1023);
    send(1023, 1023);
    send(0, -1024, 1151);
    idle(4);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL extremes_drain pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_flush();
    exp_t keep[$];
    int   held;
    repeat (6) send(rnd_sample(), rnd_sample());
    ENABLE   = 1'b0;
    IN_VALID = 1'b1;
    IN1      = W'(rnd_sample());
    IN2      = W'(rnd_sample());
    // Anything due after the flush edge is dropped in the pipe.
    foreach (sb[i]) if (sb[i].due <= cyc) keep.push_back(sb[i]);
    held = (keep.size() > 0) ? keep[keep.size()-1].val : last_exp_out;
    sb = keep;
    @(posedge CLK); #1;
    model_clear();
    n_checks++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_valid OUT_VALID=%b, required 0", OUT_VALID);
    end
    n_checks++;
    if (OUT !== OUT_W'(held)) begin
      n_fail++;
      $display("FAIL flush_hold OUT=%0d, required %0d", OUT, held);
    end
    repeat (3) send(rnd_sample(), rnd_sample());
    n_checks++;
    if (OUT !== OUT_W'(held) || OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_priming OUT=%0d OUT_VALID=%b, required %0d/0", OUT, OUT_VALID, held);
    end
    repeat (4) send(rnd_sample(), rnd_sample());
    idle(4);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL flush_drain pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_reset_midstream();
    repeat (6) send(rnd_sample(), rnd_sample());
    RES = 1'b0;
    #1;
    n_checks++;
    if (OUT !== '0 || OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midstream OUT=%0d OUT_VALID=%b, required 0/0", OUT, OUT_VALID);
    end
    sb.delete();
    model_clear();
    @(posedge CLK); #1;
    RES = 1'b1;
    repeat (6) send(rnd_sample(), rnd_sample());
    idle(4);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_midstream_drain pending=%0d, required 0", sb.size());
    end
  endtask

  initial begin
    RES = 1'b0; ENABLE = 1'b0; IN_VALID = 1'b0; IN1 = '0; IN2 = '0;
    model_clear();
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_dc();
    test_impulse_odd(0);
    test_impulse_even();
    test_extremes();
    test_impulse_odd(2);
    test_flush();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
